// File: rtl/handshake_const_rr_arbiter.sv
// rtl/handshake_const_rr_arbiter.sv - round-robin arbiter emitting a per-requester constant on one registered channel
module handshake_const_rr_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int IDX_WIDTH  = 2,
    parameter logic [NUM_REQ*DATA_WIDTH-1:0] CONST_TABLE = {32'd4, 32'd3, 32'd2, 32'd1}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    ctrl_valid,
    output logic [NUM_REQ-1:0]    ctrl_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic [IDX_WIDTH-1:0]  outs_index,
    output logic                  outs_valid,
    input  logic                  outs_ready
);

    logic [IDX_WIDTH-1:0] last_grant;
    logic [IDX_WIDTH-1:0] winner;
    logic                 found;
    logic                 can_accept;
    logic                 fire;
    logic [NUM_REQ-1:0]   shifted;
    int                   cand;

    assign can_accept = !outs_valid || outs_ready;

    // Search starts just past the last granted requester and wraps around.
    always_comb begin
        winner  = '0;
        found   = 1'b0;
        cand    = 0;
        shifted = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand    = (int'(last_grant) + 1 + k) % NUM_REQ;
            shifted = ctrl_valid >> cand;
            if (!found && shifted[0]) begin
                found  = 1'b1;
                winner = IDX_WIDTH'(cand);
            end
        end
    end

    assign fire       = found && can_accept && !rst;
    assign ctrl_ready = fire ? (NUM_REQ'(1) << winner) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            outs_valid <= 1'b0;
            outs       <= '0;
            outs_index <= '0;
            last_grant <= IDX_WIDTH'(NUM_REQ - 1);
        end else if (fire) begin
            outs       <= CONST_TABLE[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
            outs_index <= winner;
            outs_valid <= 1'b1;
            last_grant <= winner;
        end else if (outs_ready) begin
            outs_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_handshake_const_rr_arbiter.sv
// tb/tb_handshake_const_rr_arbiter.sv - scoreboard bench for handshake_const_rr_arbiter
module tb_handshake_const_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  ctrl_valid;
    logic [3:0]  ctrl_ready;
    logic [31:0] outs;
    logic [1:0]  outs_index;
    logic        outs_valid;
    logic        outs_ready;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] value;
        logic [1:0]  index;
    } tok_t;

    tok_t        sb[$];
    int          m_last;
    logic        m_ov;
    logic [31:0] tbl [4] = '{32'd1, 32'd2, 32'd3, 32'd4};

    handshake_const_rr_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .ctrl_valid (ctrl_valid),
        .ctrl_ready (ctrl_ready),
        .outs       (outs),
        .outs_index (outs_index),
        .outs_valid (outs_valid),
        .outs_ready (outs_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: drive at negedge, check against the model, then advance the model to the next edge.
    task automatic step(input logic [3:0] v, input logic ordy, input logic r);
        logic [3:0] exp_ready;
        int         w;
        logic       can;
        tok_t       t;
        @(negedge clk);
        ctrl_valid = v;
        outs_ready = ordy;
        rst        = r;
        #1;
        can = !m_ov || ordy;
        w   = -1;
        for (int k = 1; k <= 4; k++) begin
            if (w < 0 && v[(m_last + k) % 4]) w = (m_last + k) % 4;
        end
        exp_ready = (w >= 0 && can && !r) ? (4'b0001 << w) : 4'b0000;
        check("ctrl_ready", {28'd0, ctrl_ready}, {28'd0, exp_ready});
        check("outs_valid", {31'd0, outs_valid}, {31'd0, m_ov});
        if (m_ov) begin
            if (sb.size() == 0) begin
                check("sb_nonempty", 32'd0, 32'd1);
            end else begin
                check("outs", outs, sb[0].value);
                check("outs_index", {30'd0, outs_index}, {30'd0, sb[0].index});
                if (ordy && !r) void'(sb.pop_front());
            end
        end
        if (r) begin
            m_ov   = 1'b0;
            m_last = 3;
            sb.delete();
        end else if (exp_ready != 4'b0000) begin
            t.value = tbl[w];
            t.index = 2'(w);
            sb.push_back(t);
            m_last = w;
            m_ov   = 1'b1;
        end else if (ordy) begin
            m_ov = 1'b0;
        end
    endtask

    initial begin
        rst        = 1'b1;
        ctrl_valid = 4'b1111;
        outs_ready = 1'b1;
        m_ov       = 1'b0;
        m_last     = 3;
        @(posedge clk);
        #1;
        check("rst_ctrl_ready", {28'd0, ctrl_ready}, 32'd0);
        check("rst_outs_valid", {31'd0, outs_valid}, 32'd0);
        check("rst_outs", outs, 32'd0);
        check("rst_outs_index", {30'd0, outs_index}, 32'd0);
        step(4'b1111, 1'b1, 1'b1);

        // single requester, back-to-back tokens
        for (int i = 0; i < 5; i++) step(4'b0100, 1'b1, 1'b0);

        // all valid: round-robin order
        step(4'b1111, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) step(4'b1111, 1'b1, 1'b0);

        // backpressure then release
        step(4'b1111, 1'b1, 1'b1);
        step(4'b1111, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(4'b1111, 1'b0, 1'b0);
        step(4'b1111, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);

        // alternating 3/1, then only 1
        step(4'b0000, 1'b1, 1'b1);
        step(4'b0010, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(4'b1010, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(4'b0010, 1'b1, 1'b0);

        // stall, reset mid-operation, restart at requester 0
        step(4'b1111, 1'b0, 1'b0);
        step(4'b1111, 1'b0, 1'b0);
        step(4'b1111, 1'b0, 1'b1);
        step(4'b1111, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);

        check("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
